// File: rtl/alu_pkg.sv
// Shared definitions for the byte-framed ALU controller: opcode values,
// controller state encoding and an opcode-support helper.
package alu_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OPC_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OPC_W-1:0] OP_AND = 6'b100100;
    localparam logic [OPC_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OPC_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OPC_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OPC_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OPC_W-1:0] OP_NOR = 6'b100111;

    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SEND   = 3'd4
    } state_e;

    // True when the ALU implements the given opcode.
    function automatic logic is_supported_op(input logic [OPC_W-1:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_ctrl_alu.sv
// Combinational ALU: eight operations on unsigned NB_DATA-bit operands,
// results wrap modulo 2^NB_DATA, unknown opcodes produce zero.
module alu_ctrl_alu
    import alu_pkg::*;
#(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input  logic [NB_DATA-1:0]   a_i,
    input  logic [NB_DATA-1:0]   b_i,
    input  logic [NB_OPCODE-1:0] op_i,
    output logic [NB_DATA-1:0]   result_o
);

    // Shift amounts at or beyond the operand width saturate explicitly.
    localparam logic [NB_DATA:0] SHIFT_LIMIT = (NB_DATA+1)'(NB_DATA);

    logic               shift_sat_s;
    logic [OPC_W-1:0]   op_s;
    logic [NB_DATA-1:0] result_s;

    assign shift_sat_s = ({1'b0, b_i} >= SHIFT_LIMIT);
    assign op_s        = OPC_W'(op_i);

    // Operation select; anything not decoded yields zero.
    always_comb begin
        result_s = {NB_DATA{1'b0}};
        case (op_s)
            OP_ADD: result_s = a_i + b_i;
            OP_SUB: result_s = a_i - b_i;
            OP_AND: result_s = a_i & b_i;
            OP_OR:  result_s = a_i | b_i;
            OP_XOR: result_s = a_i ^ b_i;
            OP_NOR: result_s = ~(a_i | b_i);
            OP_SRA: begin
                if (shift_sat_s) begin
                    result_s = {NB_DATA{a_i[NB_DATA-1]}};
                end else begin
                    result_s = $unsigned($signed(a_i) >>> b_i);
                end
            end
            OP_SRL: begin
                if (shift_sat_s) begin
                    result_s = {NB_DATA{1'b0}};
                end else begin
                    result_s = a_i >> b_i;
                end
            end
            default: result_s = {NB_DATA{1'b0}};
        endcase
    end

    assign result_o = result_s;

endmodule

// File: rtl/alu_ctrl.sv
// Frame controller: collects operand A, operand B and opcode bytes, runs the
// ALU for one cycle, then holds the result until the consumer takes it.
// An incomplete frame is abandoned after TIMEOUT_CYC idle cycles.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int NB_DATA     = 8,
    parameter int NB_OPCODE   = 6,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [NB_DATA-1:0] tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               err,
    output logic               timeout
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

    state_e               state_q, state_d;
    logic [NB_DATA-1:0]   a_q, a_d;
    logic [NB_DATA-1:0]   b_q, b_d;
    logic [NB_OPCODE-1:0] op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 rx_ready_q, rx_ready_d;
    logic                 err_q, err_d;
    logic                 timeout_q, timeout_d;

    logic                 accept_s;
    logic [CNT_W-1:0]     cnt_inc_s;
    logic [NB_DATA-1:0]   alu_result_s;

    assign accept_s  = rx_valid & rx_ready_q;
    assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    alu_ctrl_alu #(
        .NB_DATA   (NB_DATA),
        .NB_OPCODE (NB_OPCODE)
    ) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result_s)
    );

    // Next-state and datapath decisions. timeout_q is high exactly in the
    // cycle the idle counter sits at its limit; that cycle aborts the frame
    // with rx_ready already low, so the byte presented then is refused.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_GET_A: begin
                cnt_d = {CNT_W{1'b0}};
                if (accept_s) begin
                    a_d     = rx_data;
                    state_d = ST_GET_B;
                end else begin
                    state_d = ST_GET_A;
                end
            end
            ST_GET_B, ST_GET_OP: begin
                if (timeout_q) begin
                    state_d = ST_GET_A;
                    a_d     = {NB_DATA{1'b0}};
                    b_d     = {NB_DATA{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else if (accept_s) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (state_q == ST_GET_B) begin
                        b_d     = rx_data;
                        state_d = ST_GET_OP;
                    end else begin
                        op_d    = rx_data[NB_OPCODE-1:0];
                        err_d   = ~is_supported_op(OPC_W'(rx_data[NB_OPCODE-1:0]));
                        state_d = ST_EXEC;
                    end
                end else begin
                    cnt_d     = cnt_inc_s;
                    timeout_d = (cnt_inc_s == CNT_LIMIT);
                end
            end
            ST_EXEC: begin
                tx_data_d = alu_result_s;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    state_d = ST_GET_A;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_GET_A;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        tx_valid_d = (state_d == ST_SEND);
        rx_ready_d = ((state_d == ST_GET_A) || (state_d == ST_GET_B) ||
                      (state_d == ST_GET_OP)) && !timeout_d;
    end

    // State, operand and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_GET_A;
            a_q        <= {NB_DATA{1'b0}};
            b_q        <= {NB_DATA{1'b0}};
            op_q       <= {NB_OPCODE{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            tx_data_q  <= {NB_DATA{1'b0}};
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rx_ready_q <= rx_ready_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed frames, timeout, reset and a
// randomized run compared against an arithmetic reference model.
module tb_alu_ctrl;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       err;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_ctrl #(
        .NB_DATA     (8),
        .NB_OPCODE   (6),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .err      (err),
        .timeout  (timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU from the arithmetic definition of each operation.
    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] opb, output logic ok);
        logic [5:0] op;
        int sa, p, q, ua, ub;
        logic [7:0] r;
        op = opb[5:0];
        ua = int'(a);
        ub = int'(b);
        ok = 1'b1;
        r  = 8'h00;
        case (op)
            6'b100000: r = 8'((ua + ub) % 256);
            6'b100010: r = 8'((ua - ub + 256) % 256);
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = ~(a | b);
            6'b000011: begin
                sa = (ua >= 128) ? ua - 256 : ua;
                if (ub >= 8) begin
                    r = (sa < 0) ? 8'hFF : 8'h00;
                end else begin
                    p = 1 << ub;
                    q = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
                    r = 8'(q);
                end
            end
            6'b000010: r = (ub >= 8) ? 8'h00 : 8'(ua / (1 << ub));
            default: begin
                ok = 1'b0;
                r  = 8'h00;
            end
        endcase
        return r;
    endfunction

    task automatic push_byte(input logic [7:0] d);
        int waited;
        waited = 0;
        @(negedge clk);
        rx_data  = d;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("rx_accept_bound", rx_ready, 1);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                            input int gap, input int bp);
        logic       ok;
        logic [7:0] exp;
        exp = ref_alu(a, b, o, ok);
        push_byte(a);
        idle(gap);
        push_byte(b);
        idle(gap);
        push_byte(o);
        @(negedge clk);
        rx_valid = 1'b0;
        tx_ready = (bp == 0);
        check_eq("exec_tx_valid", tx_valid, 0);
        check_eq("exec_err", err, !ok);
        check_eq("exec_rx_ready", rx_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("send_tx_valid", tx_valid, 1);
        check_eq("send_tx_data", tx_data, exp);
        check_eq("send_err", err, 0);
        for (int i = 0; i < bp; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_tx_valid", tx_valid, 1);
            check_eq("bp_tx_data", tx_data, exp);
            check_eq("bp_rx_ready", rx_ready, 0);
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("done_tx_valid", tx_valid, 0);
        check_eq("done_rx_ready", rx_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_valid"}, tx_valid, 0);
        check_eq({tag, "_tx_data"}, tx_data, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_timeout"}, timeout, 0);
    endtask

    logic [7:0] op_table [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("por_rx_ready", rx_ready, 1);
        check_eq("por_tx_valid_after", tx_valid, 0);

        // Directed arithmetic and shift cases, including saturating shifts.
        do_frame(8'h05, 8'h03, 8'h20, 0, 0);
        do_frame(8'h03, 8'h05, 8'h22, 0, 0);
        do_frame(8'h80, 8'h02, 8'h03, 0, 0);
        do_frame(8'h80, 8'h02, 8'h02, 0, 0);
        do_frame(8'h81, 8'h08, 8'h03, 0, 0);
        do_frame(8'h81, 8'h09, 8'h02, 0, 0);
        do_frame(8'h7F, 8'hFF, 8'h03, 0, 0);
        do_frame(8'hF0, 8'h0F, 8'hE7, 0, 0);
        // Unsupported opcode still completes the frame with a zero result.
        do_frame(8'h12, 8'h34, 8'hFF, 0, 0);
        // Long backpressure with stray input bytes.
        do_frame(8'h5A, 8'h0F, 8'h24, 0, 10);
        // Largest gap that must not time out.
        do_frame(8'h11, 8'h22, 8'h25, TMO - 1, 0);

        // Timeout after operand A only; the byte offered in the abort cycle is refused.
        push_byte(8'h55);
        @(negedge clk);
        rx_valid = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("tmo_pulse", timeout, (k == TMO));
            if (k == TMO) begin
                check_eq("tmo_rx_ready", rx_ready, 0);
                rx_valid = 1'b1;
                rx_data  = 8'h99;
            end
        end
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        check_eq("tmo_after_pulse", timeout, 0);
        check_eq("tmo_after_rx_ready", rx_ready, 1);
        do_frame(8'h07, 8'h01, 8'h20, 0, 0);

        // Reset after operand B: outputs clear at once, nothing emitted afterwards.
        push_byte(8'hAA);
        push_byte(8'hBB);
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("rst_mid_no_tx", tx_valid, 0);
            check_eq("rst_mid_rx_ready", rx_ready, 1);
        end

        // Reset while the result is waiting in SEND.
        tx_ready = 1'b0;
        push_byte(8'h09);
        push_byte(8'h04);
        push_byte(8'h20);
        @(negedge clk);
        rx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_send_pre_valid", tx_valid, 1);
        check_eq("rst_send_pre_data", tx_data, 8'h0D);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_send");
        @(negedge clk);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("rst_send_no_tx", tx_valid, 0);
        end
        do_frame(8'h33, 8'h11, 8'h22, 0, 0);

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ra, rb, ro;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            ro = ($urandom_range(0, 4) == 0) ? 8'($urandom) : op_table[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1) begin
                ro = ro | 8'hC0;
            end else begin
                ro = ro & 8'h3F;
            end
            do_frame(ra, rb, ro, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
